// File: rtl/mips_result_capture_pkg.sv
// Shared constants for the MIPS result-capture slice: bus width and
// default watch address / FIFO geometry.
package mips_result_capture_pkg;

  localparam int unsigned DATA_W       = 32;
  localparam logic [31:0] WATCH_PC_DEF = 32'h0000_0008;
  localparam int unsigned DEPTH_DEF    = 8;
  localparam int unsigned SEQ_W_DEF    = 8;

endpackage

// File: rtl/mips_result_capture_cap_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; the head entry
// reads as zero while the FIFO is empty.
module cap_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        level_d = level_q + LVL_W'(1);
      end else if (!push && pop) begin
        level_d = level_q - LVL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_W'(DEPTH));
  assign level = level_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/mips_result_capture.sv
// Captures the core's ALU result whenever the PC hits WATCH_PC, tags it
// with a sequence number and streams it out; tracks drops and ordering.
module mips_result_capture
  import mips_result_capture_pkg::*;
#(
  parameter logic [31:0] WATCH_PC = WATCH_PC_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned SEQ_W    = SEQ_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       pc_in,
  input  logic [DATA_W-1:0]       alu_in,
  input  logic                    cap_en,
  input  logic                    clear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [SEQ_W-1:0]        out_seq,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic                    order_err
);

  logic                    take, pop, push, drop;
  logic                    full, empty;
  logic [SEQ_W+DATA_W-1:0] head;

  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              first_q, first_d;
  logic              overflow_q, overflow_d;
  logic              order_err_q, order_err_d;

  // A hit coinciding with clear is discarded entirely, including its seq tick.
  always_comb begin
    take        = cap_en && (pc_in == WATCH_PC) && !clear;
    pop         = !empty && out_ready;
    push        = take && (!full || pop);
    drop        = take && full && !pop;
    seq_d       = seq_q;
    prev_d      = prev_q;
    first_d     = first_q;
    overflow_d  = overflow_q;
    order_err_d = order_err_q;
    if (clear) begin
      seq_d       = '0;
      prev_d      = '0;
      first_d     = 1'b1;
      overflow_d  = 1'b0;
      order_err_d = 1'b0;
    end else begin
      if (take) begin
        seq_d = seq_q + SEQ_W'(1);
      end
      if (drop) begin
        overflow_d = 1'b1;
      end
      if (push) begin
        if (!first_q && (alu_in < prev_q)) begin
          order_err_d = 1'b1;
        end
        prev_d  = alu_in;
        first_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q       <= '0;
      prev_q      <= '0;
      first_q     <= 1'b1;
      overflow_q  <= 1'b0;
      order_err_q <= 1'b0;
    end else begin
      seq_q       <= seq_d;
      prev_q      <= prev_d;
      first_q     <= first_d;
      overflow_q  <= overflow_d;
      order_err_q <= order_err_d;
    end
  end

  cap_fifo #(
    .WIDTH (SEQ_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .din   ({seq_q, alu_in}),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign out_seq   = head[SEQ_W+DATA_W-1:DATA_W];
  assign out_data  = head[DATA_W-1:0];
  assign overflow  = overflow_q;
  assign order_err = order_err_q;

endmodule
